// File: rtl/toy_mem_pkg.sv
// Shared definitions for the toy memory responder: FSM states, data-direction
// encoding, default array geometry and the address range helper.
package toy_mem_pkg;

   localparam int   AW_DEFAULT = 10;
   localparam int   DATA_W     = 32;
   localparam int   ADDR_W     = 30;

   localparam logic DRW_RD     = 1'b0;
   localparam logic DRW_WR     = 1'b1;

   typedef enum logic [1:0] {
      LOAD  = 2'd0,
      DRAIN = 2'd1,
      RUN   = 2'd2
   } state_t;

   // True when any word-address bit above the array index width is set.
   function automatic logic addr_oob(input logic [ADDR_W-1:0] addr, input int aw);
      return ((addr >> aw) != '0);
   endfunction

endpackage

// File: rtl/toy_mem_array.sv
// 2-read / 1-write synchronous word array. The single write port is shared by
// the preloader and the CPU data port; read data is registered per port and
// forced to zero for out-of-range requests. Contents have no reset.
module toy_mem_array
   import toy_mem_pkg::*;
#(
   parameter int AW = AW_DEFAULT
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_ld_sel,
   input  logic              i_ld_we,
   input  logic [AW-1:0]     i_ld_addr,
   input  logic [DATA_W-1:0] i_ld_data,
   input  logic              i_cpu_we,
   input  logic [AW-1:0]     i_cpu_addr,
   input  logic [DATA_W-1:0] i_cpu_data,
   input  logic              i_ire,
   input  logic              i_ioob,
   input  logic [AW-1:0]     i_iaddr,
   output logic [DATA_W-1:0] o_idata,
   input  logic              i_dre,
   input  logic              i_doob,
   input  logic [AW-1:0]     i_daddr,
   output logic [DATA_W-1:0] o_ddata
);

   localparam int DEPTH = 2**AW;

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [DATA_W-1:0] r_idata;
   logic [DATA_W-1:0] r_ddata;
   logic              w_we;
   logic [AW-1:0]     w_waddr;
   logic [DATA_W-1:0] w_wdata;

   // Select the write source: loader while preloading, CPU data port otherwise.
   always_comb begin
      w_we    = i_cpu_we;
      w_waddr = i_cpu_addr;
      w_wdata = i_cpu_data;
      if (i_ld_sel) begin
         w_we    = i_ld_we;
         w_waddr = i_ld_addr;
         w_wdata = i_ld_data;
      end
   end

   // Array write; deliberately unreset so the image survives a CPU restart.
   always_ff @(posedge i_clk) begin
      if (w_we) begin
         r_mem[w_waddr] <= w_wdata;
      end
   end

   // Instruction read register; sees the pre-write word on a same-cycle collision.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_idata <= '0;
      end else if (i_ire) begin
         r_idata <= i_ioob ? '0 : r_mem[i_iaddr];
      end
   end

   // Data read register; holds its value on writes and idle cycles.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_ddata <= '0;
      end else if (i_dre) begin
         r_ddata <= i_doob ? '0 : r_mem[i_daddr];
      end
   end

   assign o_idata = r_idata;
   assign o_ddata = r_ddata;

endmodule

// File: rtl/toy_mem_resp.sv
// Toy memory responder: accepts a preload image over a valid/ready stream,
// then releases the CPU from reset and serves instruction fetches and data
// reads/writes from a shared array. Out-of-range accesses raise a sticky ERR.
module toy_mem_resp
   import toy_mem_pkg::*;
#(
   parameter int AW = AW_DEFAULT
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic                IREQ,
   input  logic [ADDR_W-1:0]   IADDR,
   output logic [DATA_W-1:0]   INSTR,
   input  logic                DREQ,
   input  logic                DRW,
   input  logic [ADDR_W-1:0]   DADDR,
   input  logic [DATA_W-1:0]   DWDATA,
   output logic [DATA_W-1:0]   DRDATA,
   input  logic                LD_VALID,
   output logic                LD_READY,
   input  logic [ADDR_W-1:0]   LD_ADDR,
   input  logic [DATA_W-1:0]   LD_DATA,
   input  logic                LD_LAST,
   output logic                CPU_RSTN,
   output logic                ERR
);

   state_t r_state;
   state_t w_state_nxt;
   logic   r_ld_ready;
   logic   r_cpu_rstn;
   logic   r_err;

   logic   w_run;
   logic   w_ld_acc;
   logic   w_ld_oob;
   logic   w_i_oob;
   logic   w_d_oob;
   logic   w_ire;
   logic   w_dre;
   logic   w_dwe;
   logic   w_ld_we;
   logic   w_err_set;

   assign w_run     = (r_state == RUN);
   assign w_ld_acc  = LD_VALID & r_ld_ready & (r_state == LOAD);
   assign w_ld_oob  = addr_oob(LD_ADDR, AW);
   assign w_i_oob   = addr_oob(IADDR, AW);
   assign w_d_oob   = addr_oob(DADDR, AW);

   assign w_ld_we   = w_ld_acc & ~w_ld_oob;
   assign w_ire     = w_run & IREQ;
   assign w_dre     = w_run & DREQ & (DRW == DRW_RD);
   assign w_dwe     = w_run & DREQ & (DRW == DRW_WR) & ~w_d_oob;
   assign w_err_set = (w_ld_acc & w_ld_oob) | (w_ire & w_i_oob) | (w_run & DREQ & w_d_oob);

   // Next-state logic: finish preload on the last word, one drain cycle, then run.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         LOAD:    if (w_ld_acc && LD_LAST) w_state_nxt = DRAIN;
         DRAIN:   w_state_nxt = RUN;
         RUN:     w_state_nxt = RUN;
         default: w_state_nxt = LOAD;
      endcase
   end

   // Control registers; reset drops CPU_RSTN and LD_READY immediately.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state    <= LOAD;
         r_ld_ready <= 1'b0;
         r_cpu_rstn <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_ld_ready <= (w_state_nxt == LOAD);
         r_cpu_rstn <= (w_state_nxt == RUN);
         r_err      <= r_err | w_err_set;
      end
   end

   toy_mem_array #(
      .AW(AW)
   ) u_array (
      .i_clk      (CLK),
      .i_rst      (RST),
      .i_ld_sel   (r_state == LOAD),
      .i_ld_we    (w_ld_we),
      .i_ld_addr  (LD_ADDR[AW-1:0]),
      .i_ld_data  (LD_DATA),
      .i_cpu_we   (w_dwe),
      .i_cpu_addr (DADDR[AW-1:0]),
      .i_cpu_data (DWDATA),
      .i_ire      (w_ire),
      .i_ioob     (w_i_oob),
      .i_iaddr    (IADDR[AW-1:0]),
      .o_idata    (INSTR),
      .i_dre      (w_dre),
      .i_doob     (w_d_oob),
      .i_daddr    (DADDR[AW-1:0]),
      .o_ddata    (DRDATA)
   );

   assign LD_READY = r_ld_ready;
   assign CPU_RSTN = r_cpu_rstn;
   assign ERR      = r_err;

endmodule

// File: tb/tb_toy_mem_resp.sv
// Self-checking bench for toy_mem_resp: a word-level reference image plus
// expected-result queues for the instruction and data read ports.
module tb_toy_mem_resp;

   localparam int AW    = 10;
   localparam int DEPTH = 1 << AW;

   logic        CLK;
   logic        RST;
   logic        IREQ;
   logic [29:0] IADDR;
   logic [31:0] INSTR;
   logic        DREQ;
   logic        DRW;
   logic [29:0] DADDR;
   logic [31:0] DWDATA;
   logic [31:0] DRDATA;
   logic        LD_VALID;
   logic        LD_READY;
   logic [29:0] LD_ADDR;
   logic [31:0] LD_DATA;
   logic        LD_LAST;
   logic        CPU_RSTN;
   logic        ERR;

   int          n_checks = 0;
   int          n_fail   = 0;

   logic [31:0] m_mem [DEPTH];
   logic [31:0] q_instr [$];
   logic [31:0] q_drdata [$];
   logic [31:0] last_instr  = '0;
   logic [31:0] last_drdata = '0;
   logic        exp_err     = 1'b0;

   toy_mem_resp #(.AW(AW)) dut (
      .CLK      (CLK),
      .RST      (RST),
      .IREQ     (IREQ),
      .IADDR    (IADDR),
      .INSTR    (INSTR),
      .DREQ     (DREQ),
      .DRW      (DRW),
      .DADDR    (DADDR),
      .DWDATA   (DWDATA),
      .DRDATA   (DRDATA),
      .LD_VALID (LD_VALID),
      .LD_READY (LD_READY),
      .LD_ADDR  (LD_ADDR),
      .LD_DATA  (LD_DATA),
      .LD_LAST  (LD_LAST),
      .CPU_RSTN (CPU_RSTN),
      .ERR      (ERR)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   initial begin
      #2000000;
      $display("FAIL timeout reached");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   function automatic logic is_oob(input logic [29:0] a);
      return a >= 30'(DEPTH);
   endfunction

   task automatic ld_word(input logic [29:0] a, input logic [31:0] d, input logic last);
      LD_VALID = 1'b1;
      LD_ADDR  = a;
      LD_DATA  = d;
      LD_LAST  = last;
      step();
      LD_VALID = 1'b0;
      LD_LAST  = 1'b0;
      if (is_oob(a)) exp_err = 1'b1;
      else           m_mem[a[AW-1:0]] = d;
   endtask

   task automatic fetch(input string tag, input logic [29:0] a);
      IREQ  = 1'b1;
      IADDR = a;
      if (is_oob(a)) begin
         q_instr.push_back(32'h0);
         exp_err = 1'b1;
      end else begin
         q_instr.push_back(m_mem[a[AW-1:0]]);
      end
      step();
      IREQ = 1'b0;
      last_instr = q_instr.pop_front();
      chk(tag, INSTR, last_instr);
   endtask

   task automatic dacc(input string tag, input logic rw, input logic [29:0] a, input logic [31:0] d);
      DREQ   = 1'b1;
      DRW    = rw;
      DADDR  = a;
      DWDATA = d;
      if (is_oob(a)) exp_err = 1'b1;
      if (!rw) q_drdata.push_back(is_oob(a) ? 32'h0 : m_mem[a[AW-1:0]]);
      else if (!is_oob(a)) m_mem[a[AW-1:0]] = d;
      step();
      DREQ = 1'b0;
      if (!rw) last_drdata = q_drdata.pop_front();
      chk(tag, DRDATA, last_drdata);
   endtask

   initial begin
      logic [29:0] ra;
      logic [31:0] rd;

      RST = 1'b1; IREQ = 1'b0; IADDR = '0; DREQ = 1'b0; DRW = 1'b0;
      DADDR = '0; DWDATA = '0; LD_VALID = 1'b0; LD_ADDR = '0; LD_DATA = '0;
      LD_LAST = 1'b0;

      // Reset state
      step(); step();
      chk("rst_instr",    INSTR,    32'h0);
      chk("rst_drdata",   DRDATA,   32'h0);
      chk("rst_ld_ready", {31'b0, LD_READY}, 32'h0);
      chk("rst_cpu_rstn", {31'b0, CPU_RSTN}, 32'h0);
      chk("rst_err",      {31'b0, ERR},      32'h0);
      RST = 1'b0;
      #1;
      chk("ld_ready_pre_edge", {31'b0, LD_READY}, 32'h0);
      step();
      chk("ld_ready_rise", {31'b0, LD_READY}, 32'h1);

      // Fetch requests are ignored while preloading
      IREQ = 1'b1; IADDR = 30'd0;
      step();
      IREQ = 1'b0;
      chk("load_ignores_ireq", INSTR, 32'h0);

      // Preload two words
      ld_word(30'd0, 32'h11111111, 1'b0);
      chk("ld_ready_mid", {31'b0, LD_READY}, 32'h1);
      chk("cpu_rstn_load", {31'b0, CPU_RSTN}, 32'h0);
      ld_word(30'd1, 32'h22222222, 1'b1);
      chk("ld_ready_drop", {31'b0, LD_READY}, 32'h0);
      chk("cpu_rstn_drain", {31'b0, CPU_RSTN}, 32'h0);
      step();
      chk("cpu_rstn_run", {31'b0, CPU_RSTN}, 32'h1);
      chk("ld_ready_run", {31'b0, LD_READY}, 32'h0);

      // Fetch and hold
      fetch("fetch_a1", 30'd1);
      step();
      chk("instr_hold", INSTR, last_instr);
      fetch("fetch_a0", 30'd0);

      // Write then read back the next cycle
      dacc("wr5_hold", 1'b1, 30'd5, 32'hDEADBEEF);
      dacc("rd5", 1'b0, 30'd5, 32'h0);
      step();
      chk("drdata_hold", DRDATA, last_drdata);

      // Same-cycle data write and fetch of one address
      IREQ = 1'b1; IADDR = 30'd0;
      DREQ = 1'b1; DRW = 1'b1; DADDR = 30'd0; DWDATA = 32'hCAFEF00D;
      q_instr.push_back(m_mem[0]);
      m_mem[0] = 32'hCAFEF00D;
      step();
      IREQ = 1'b0; DREQ = 1'b0;
      last_instr = q_instr.pop_front();
      chk("collide_old", INSTR, last_instr);
      fetch("collide_new", 30'd0);

      // Mixed random write/read traffic in range
      for (int i = 0; i < 6; i++) begin
         ra = 30'(8 + $urandom_range(0, 7));
         rd = $urandom;
         dacc("rnd_wr", 1'b1, ra, rd);
         dacc("rnd_rd", 1'b0, ra, 32'h0);
         fetch("rnd_fetch", ra);
      end
      chk("err_clear", {31'b0, ERR}, {31'b0, exp_err});

      // Out-of-range accesses
      dacc("rd_oob", 1'b0, 30'h400, 32'h0);
      chk("err_set", {31'b0, ERR}, {31'b0, exp_err});
      dacc("wr_oob_hold", 1'b1, 30'h400, 32'h12345678);
      step(); step();
      chk("err_sticky", {31'b0, ERR}, 32'h1);
      fetch("addr0_after_oob", 30'd0);
      fetch("fetch_oob", 30'h401);

      // Mid-run reset with a write in flight
      @(posedge CLK);
      #1;
      DREQ = 1'b1; DRW = 1'b1; DADDR = 30'd1; DWDATA = 32'hBAD0BAD0;
      #2;
      RST = 1'b1;
      #1;
      chk("mrst_cpu_rstn", {31'b0, CPU_RSTN}, 32'h0);
      chk("mrst_err",      {31'b0, ERR},      32'h0);
      chk("mrst_instr",    INSTR,  32'h0);
      chk("mrst_drdata",   DRDATA, 32'h0);
      step();
      DREQ = 1'b0;
      RST  = 1'b0;
      exp_err = 1'b0;
      last_instr  = '0;
      last_drdata = '0;
      step();
      chk("reload_ready", {31'b0, LD_READY}, 32'h1);
      chk("reload_cpu_rstn", {31'b0, CPU_RSTN}, 32'h0);
      ld_word(30'd2, 32'h33333333, 1'b1);
      step();
      chk("rerun_cpu_rstn", {31'b0, CPU_RSTN}, 32'h1);
      fetch("retained_a1", 30'd1);
      fetch("reloaded_a2", 30'd2);
      dacc("retained_rd5", 1'b0, 30'd5, 32'h0);
      chk("err_after_reload", {31'b0, ERR}, {31'b0, exp_err});

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
